instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 95 +++++++++
 tb/tb_instr_fetch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: requests imem[pc], holds the returned word for issue, then steers pc.
// Latency: one FETCH cycle per imemReady plus one ISSUE cycle; backpressure via imemReady wait and stall hold.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [5:0]  opCode,
    output logic [31:0] instr,
    output logic        instrValid,
    output logic [31:0] pcPlus4,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] immExt,
    input  logic        stall,
    output logic [31:0] instCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [31:0] pc;
    logic [31:0] nextPc;
    logic [31:0] branchTarget;
    logic        capture;
    logic        retire;

    assign pcPlus4      = pc + 32'd4;
    assign branchTarget = pcPlus4 + (immExt << 2);
    assign capture      = (state == FETCH) && imemReady;
    assign retire       = (state == ISSUE) && !stall;

    // Jump outranks branch; every source keeps the low two bits zero.
    always_comb begin
        nextPc = pcPlus4;
        if (jump) begin
            nextPc = {pcPlus4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            nextPc = branchTarget;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = FETCH;
            FETCH:   if (imemReady) nextState = ISSUE;
            ISSUE:   if (!stall) nextState = FETCH;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        imemReq    = (state == FETCH);
        instrValid = (state == ISSUE);
        imemAddr   = pc;
        // Undecoded opcode keeps downstream control quiet outside ISSUE.
        opCode     = instrValid ? instr[31:26] : 6'b111111;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= {RESET_PC[31:2], 2'b00};
            instr     <= 32'h0;
            instCount <= 32'h0;
        end else begin
            if (capture) begin
                instr <= imemData;
            end
            if (retire) begin
                pc        <= nextPc;
                instCount <= instCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a queue holds expected fetch addresses from a reference pc model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;
    logic [5:0]  opCode;
    logic [31:0] instr;
    logic        instrValid;
    logic [31:0] pcPlus4;
    logic        jump;
    logic        branch;
    logic        zero;
    logic [31:0] immExt;
    logic        stall;
    logic [31:0] instCount;

    int checks   = 0;
    int failures = 0;

    logic [31:0] expQ[$];
    logic [31:0] mPc;
    logic [31:0] mCount;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h00000000)) dut (
        .clk        (clk),
        .reset      (reset),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemReady  (imemReady),
        .imemData   (imemData),
        .opCode     (opCode),
        .instr      (instr),
        .instrValid (instrValid),
        .pcPlus4    (pcPlus4),
        .jump       (jump),
        .branch     (branch),
        .zero       (zero),
        .immExt     (immExt),
        .stall      (stall),
        .instCount  (instCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] modelNext(input logic [31:0] pc, input logic [31:0] ins,
                                              input logic j, input logic b, input logic z,
                                              input logic [31:0] imm);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (j)           return {p4[31:28], ins[25:0], 2'b00};
        else if (b && z) return p4 + (imm << 2);
        else             return p4;
    endfunction

    task automatic waitFetch();
        int n = 0;
        while (!imemReq && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_timeout", imemReq, 1);
    endtask

    // One FETCH/ISSUE round trip; slow delays imemReady, stallN holds ISSUE.
    task automatic fetchIssue(input logic [31:0] word, input logic j, input logic b,
                              input logic z, input logic [31:0] imm,
                              input int stallN, input int slow);
        logic [31:0] exp;
        waitFetch();
        exp = expQ.pop_front();
        chk("fetch_addr", imemAddr, exp);
        for (int i = 0; i < slow; i++) begin
            imemReady = 1'b0;
            @(negedge clk);
            chk("slow_req", imemReq, 1);
            chk("slow_addr", imemAddr, exp);
            chk("slow_valid", instrValid, 0);
        end
        imemReady = 1'b1;
        imemData  = word;
        @(negedge clk);
        imemReady = 1'b0;
        chk("issue_valid", instrValid, 1);
        chk("issue_instr", instr, word);
        chk("issue_opcode", {26'h0, opCode}, {26'h0, word[31:26]});
        chk("issue_req", imemReq, 0);
        jump   = j;
        branch = b;
        zero   = z;
        immExt = imm;
        for (int i = 0; i < stallN; i++) begin
            stall     = 1'b1;
            imemReady = 1'b1;
            imemData  = ~word;
            @(negedge clk);
            chk("stall_instr", instr, word);
            chk("stall_pc", imemAddr, exp);
            chk("stall_count", instCount, mCount);
            chk("stall_req", imemReq, 0);
            chk("stall_valid", instrValid, 1);
        end
        stall     = 1'b0;
        imemReady = 1'b0;
        @(negedge clk);
        mPc    = modelNext(exp, word, j, b, z, imm);
        mCount = mCount + 32'd1;
        expQ.push_back(mPc);
        jump   = 1'b0;
        branch = 1'b0;
        zero   = 1'b0;
        immExt = 32'h0;
        chk("retire_count", instCount, mCount);
        chk("retire_valid", instrValid, 0);
        chk("retire_opcode", {26'h0, opCode}, 32'h3F);
        chk("retire_hold", instr, word);
        chk("retire_req", imemReq, 1);
        chk("retire_pc4", pcPlus4, mPc + 32'd4);
    endtask

    initial begin
        reset     = 1'b1;
        imemReady = 1'b0;
        imemData  = 32'h0;
        jump      = 1'b0;
        branch    = 1'b0;
        zero      = 1'b0;
        immExt    = 32'h0;
        stall     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", imemReq, 0);
        chk("rst_valid", instrValid, 0);
        chk("rst_opcode", {26'h0, opCode}, 32'h3F);
        chk("rst_instr", instr, 32'h0);
        chk("rst_count", instCount, 32'h0);
        chk("rst_addr", imemAddr, 32'h0);
        reset  = 1'b0;
        mPc    = 32'h0;
        mCount = 32'h0;
        expQ.push_back(mPc);

        // Sequential flow: 0x0, 0x4, 0x8
        fetchIssue(32'h20010001, 0, 0, 0, 32'h0, 0, 0);
        fetchIssue(32'h8C020004, 0, 0, 0, 32'h0, 0, 0);
        fetchIssue(32'h00221820, 0, 0, 0, 32'h0, 0, 0);
        chk("seq_count3", instCount, 32'd3);
        chk("seq_addr_c", imemAddr, 32'h0000000C);

        // Jump into 0x00400010, then the jump vector with a 3-cycle stall
        fetchIssue(32'h08100004, 1, 0, 0, 32'h0, 0, 0);
        chk("jmp_setup", imemAddr, 32'h00400010);
        fetchIssue(32'h08100040, 1, 0, 0, 32'h0, 3, 0);
        chk("jmp_target", imemAddr, 32'h00400100);

        // jump and branch together: jump wins
        fetchIssue(32'h08000040, 1, 1, 1, 32'h00000005, 0, 0);
        chk("jmp_prio", imemAddr, 32'h00000100);

        // Taken backward branch with 4-cycle slow memory
        fetchIssue(32'h1000FFFE, 0, 1, 1, 32'hFFFFFFFE, 0, 4);
        chk("br_taken", imemAddr, 32'h000000FC);
        fetchIssue(32'h08000040, 1, 0, 0, 32'h0, 0, 0);
        fetchIssue(32'h1000FFFE, 0, 1, 0, 32'hFFFFFFFE, 0, 0);
        chk("br_not_taken", imemAddr, 32'h00000104);

        // Branch to the top of memory, then wrap
        fetchIssue(32'h1000FFBD, 0, 1, 1, 32'hFFFFFFBD, 0, 0);
        chk("wrap_setup", imemAddr, 32'hFFFFFFFC);
        fetchIssue(32'h00000000, 0, 0, 0, 32'h0, 0, 0);
        chk("wrap_addr", imemAddr, 32'h00000000);
        fetchIssue(32'h00000000, 0, 0, 0, 32'h0, 0, 0);

        // Reset while in FETCH at 0x4 with a response on the same edge
        waitFetch();
        chk("prerst_addr", imemAddr, 32'h00000004);
        imemReady = 1'b1;
        imemData  = 32'hDEADBEEF;
        stall     = 1'b1;
        jump      = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        chk("midrst_valid", instrValid, 0);
        chk("midrst_addr", imemAddr, 32'h0);
        chk("midrst_instr", instr, 32'h0);
        chk("midrst_count", instCount, 32'h0);
        chk("midrst_req", imemReq, 0);
        chk("midrst_opcode", {26'h0, opCode}, 32'h3F);
        reset = 1'b0;
        stall = 1'b0;
        jump  = 1'b0;
        @(negedge clk);
        chk("postrst_instr", instr, 32'h0);
        chk("postrst_valid", instrValid, 0);
        chk("postrst_req", imemReq, 1);
        imemReady = 1'b0;
        expQ.delete();
        mPc    = 32'h0;
        mCount = 32'h0;
        expQ.push_back(mPc);
        fetchIssue(32'h20030007, 0, 0, 0, 32'h0, 0, 0);
        chk("postrst_next", imemAddr, 32'h00000004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
